// File: rtl/sar_search_8bit_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_search_8bit_pkg;

  localparam int SAR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_search_8bit_if.sv
// Search-engine <-> comparator/controller signal bundle.
interface sar_search_8bit_if
  import sar_search_8bit_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  // The search engine asks (drives guess); the comparator side answers.
  modport master (
    input  start, cmp_eq, cmp_gt, cmp_lt,
    output guess, busy, done, result, found, err
  );

  modport slave (
    output start, cmp_eq, cmp_gt, cmp_lt,
    input  guess, busy, done, result, found, err
  );
endinterface

// File: rtl/sar_search_8bit.sv
// Successive-approximation search: presents trial values to an external
// magnitude comparator and resolves one bit per compare cycle.
module sar_search_8bit
  import sar_search_8bit_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  sar_search_8bit_if.master bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] guess_step;
  logic [2:0]       resp;

  assign resp = {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt};

  // Trial value after a legal gt/lt answer: resolve bit idx, probe the next one.
  always_comb begin
    guess_step = bus.guess;
    if (bus.cmp_lt) guess_step[idx] = 1'b0;
    if (idx != '0) guess_step[idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      bus.guess  <= '0;
      bus.result <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.found  <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.guess <= {1'b1, {(WIDTH-1){1'b0}}};
            idx       <= IDX_W'(WIDTH - 1);
            bus.found <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= ST_SEARCH;
          end
        end

        ST_SEARCH: begin
          case (resp)
            3'b100: begin
              bus.result <= bus.guess;
              bus.found  <= 1'b1;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state      <= ST_DONE;
            end
            3'b010, 3'b001: begin
              bus.guess <= guess_step;
              if (idx != '0) begin
                idx <= idx - 1'b1;
              end else begin
                // Last bit resolved without an exact hit.
                bus.result <= guess_step;
                bus.found  <= 1'b0;
                bus.busy   <= 1'b0;
                bus.done   <= 1'b1;
                state      <= ST_DONE;
              end
            end
            default: begin
              bus.result <= bus.guess;
              bus.err    <= 1'b1;
              bus.found  <= 1'b0;
              bus.busy   <= 1'b0;
              bus.done   <= 1'b1;
              state      <= ST_DONE;
            end
          endcase
        end

        ST_DONE: begin
          bus.done <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_search_8bit.md
# sar_search_8bit

Successive-approximation search engine that drives the B-side operand of an external 8-bit magnitude comparator and consumes its eq/gt/lt results. It finds an unknown 8-bit target value in at most 8 comparisons. It sits on the opposite side of the comparator interface from the comparator itself: the comparator answers, this block asks. Typical uses are threshold discovery and SAR-style trimming loops.

## Interface
Parameters:
- WIDTH, 8, operand width; the search takes at most WIDTH compare cycles.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a search; sampled only in IDLE.
- guess  out  WIDTH  registered trial value driven to the comparator B input.
- cmp_eq  in  1  comparator result: target == guess.
- cmp_gt  in  1  comparator result: target > guess.
- cmp_lt  in  1  comparator result: target < guess.
- busy  out  1  high while in SEARCH.
- done  out  1  one-cycle pulse when a search ends.
- result  out  WIDTH  final value; held until the next start.
- found  out  1  an eq result was observed; valid with done, held afterwards.
- err  out  1  an illegal comparator response was seen; valid with done, held afterwards.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE, start=1 → SEARCH:
  - guess ← 1 at bit WIDTH-1, 0 elsewhere (0x80); bit index i ← WIDTH-1.
  - found, err ← 0.
- SEARCH, each cycle, exactly one of cmp_eq/gt/lt expected:
  - cmp_eq: result ← guess, found ← 1, go to DONE.
  - cmp_lt: clear guess[i].
  - cmp_gt: keep guess[i].
  - After lt or gt with i>0: set guess[i-1], i ← i-1.
  - After lt or gt with i==0: result ← the updated guess, found ← 0, go to DONE.
- Illegal response (zero or more than one cmp_* high): err ← 1, found ← 0, result ← current guess, go to DONE.
- DONE: done=1 for this cycle only, then unconditionally return to IDLE.
- guess holds its last value in IDLE and DONE.
- start while in SEARCH or DONE is ignored; it is not queued.
- cmp_* inputs are ignored outside SEARCH.
- Arithmetic: bit set/clear only, no adders. The bit index is a 3-bit down-counter that never wraps: it stops at 0.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, guess=0, result=0, busy=0, done=0, found=0, err=0. A search in progress is aborted with no done pulse.
- start sampled at edge 0. guess=0x80 and busy=1 from cycle 1.
- The comparator is combinational: cmp_* is sampled at the same edge that guess was presented to (zero-cycle comparator latency).
- Compare k happens in cycle k. A decision at edge k makes done=1 in cycle k+1, with busy=0 in that cycle.
- Latency from start to done: minimum 2 cycles (eq on the first compare), maximum WIDTH+1 = 9 cycles.
- result, found and err update at the same edge that raises done.
- The earliest accepted new start is in the cycle after done.

## Structure
- Shared package: state enum (IDLE, SEARCH, DONE) and WIDTH default constant.
- Single flat module; no sub-module is required.
- Bench instantiates the existing 8-bit comparator as the response model (A = target, B = guess).

## Test plan
- Target 0x80, start → guess 0x80, eq at cycle 1; done in cycle 2, result=0x80, found=1, err=0.
- Target 0x5A → guess sequence 80,40,60,50,58,5C,5A; eq at cycle 7; done in cycle 8, result=0x5A, found=1.
- Target 0x00 → guesses 80,40,20,10,08,04,02,01, all lt; done in cycle 9, result=0x00, found=0.
- Target 0xFF → guesses 80,C0,E0,F0,F8,FC,FE,FF, eq on the last; done in cycle 9, result=0xFF, found=1.
- Force cmp_gt=cmp_lt=1 at cycle 3 → done in cycle 4, err=1, found=0, result=0x60 (target 0x5A path).
- Second start pulse in cycle 4 of a search → ignored, the original search completes normally. rst_n low at cycle 5 → all outputs 0 immediately, no done. A fresh start then completes normally.
